// File: rtl/mor1kx_spr_initiator.sv
// rtl/mor1kx_spr_initiator.sv - SPR bus initiator: one request in, one SPR bus access, one response out
//
// Purpose: turns a single mtspr/mfspr request into a strobed SPR bus access.
// The access is held until the responder acks or TIMEOUT cycles elapse.
// The result is then presented as a response. Only one transaction is
// outstanding at a time.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid_i / req_ready_o      request handshake
//   req_we_i, req_addr_i,          request write flag, SPR address, write data
//   req_dat_i
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_dat_o, rsp_err_o           read data (0 for writes/errors), timeout flag
//   spr_access_o, spr_we_o,        SPR bus strobe, write enable, address, write data
//   spr_addr_o, spr_dat_o
//   spr_bus_ack_i, spr_dat_i       responder ack and read data
module mor1kx_spr_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        spr_access_o,
  output logic        spr_we_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_dat_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // 9 bits hold the largest legal TIMEOUT (256) without wrapping.
  localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);

  logic [1:0]  state_q,   state_d;
  logic        we_q,      we_d;
  logic [15:0] addr_q,    addr_d;
  logic [31:0] dat_q,     dat_d;
  logic [8:0]  cnt_q,     cnt_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic [8:0]  cnt_inc;

  // Number of ACCESS cycles elapsed, including the current one.
  assign cnt_inc = cnt_q + 9'd1;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          dat_d   = req_dat_i;
          cnt_d   = 9'd0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // The ack is checked first, so an ack in the final cycle wins over the timeout.
        if (spr_bus_ack_i) begin
          rsp_dat_d = we_q ? 32'd0 : spr_dat_i;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          cnt_d     = cnt_inc;
          rsp_dat_d = 32'd0;
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= 16'd0;
      dat_q     <= 32'd0;
      cnt_q     <= 9'd0;
      rsp_dat_q <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Every output comes from registers or the state decode; spr_bus_ack_i never reaches an output directly.
  assign req_ready_o  = (state_q == ST_IDLE);
  assign spr_access_o = (state_q == ST_ACCESS);
  assign spr_we_o     = (state_q == ST_ACCESS) & we_q;
  assign spr_addr_o   = addr_q;
  assign spr_dat_o    = dat_q;
  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_mor1kx_spr_initiator.sv
// tb/tb_mor1kx_spr_initiator.sv - scoreboard bench for mor1kx_spr_initiator
module tb_mor1kx_spr_initiator;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [15:0] req_addr_i = 16'd0;
  logic [31:0] req_dat_i = 32'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        spr_access_o;
  logic        spr_we_o;
  logic [15:0] spr_addr_o;
  logic [31:0] spr_dat_o;
  logic        spr_bus_ack_i = 1'b0;
  logic [31:0] spr_dat_i = 32'd0;

  mor1kx_spr_initiator #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .spr_access_o(spr_access_o), .spr_we_o(spr_we_o),
    .spr_addr_o(spr_addr_o), .spr_dat_o(spr_dat_o),
    .spr_bus_ack_i(spr_bus_ack_i), .spr_dat_i(spr_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] dat;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_acc;
  } txn_t;

  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic hold_low = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the responder acks after 'delay' wait cycles; if that is
  // not inside the TIMEOUT window the access times out after TIMEOUT cycles.
  function automatic txn_t model(input logic we, input logic [15:0] a, input logic [31:0] d,
                                 input int dly, input logic [31:0] rd);
    txn_t t;
    t.we = we; t.addr = a; t.dat = d; t.delay = dly; t.rdata = rd;
    if (dly < TIMEOUT) begin
      t.exp_err = 1'b0;
      t.exp_dat = we ? 32'd0 : rd;
      t.exp_acc = dly + 1;
    end else begin
      t.exp_err = 1'b1;
      t.exp_dat = 32'd0;
      t.exp_acc = TIMEOUT;
    end
    return t;
  endfunction

  // Response backpressure: random, or held low on demand.
  always @(posedge clk) begin
    #1;
    rsp_ready_i = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Responder and monitor: everything sampled on the falling edge.
  int          acc_cycles = 0;
  logic        prev_access = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_dat = 32'd0;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      acc_cycles  = 0;
      prev_access = 1'b0;
      prev_hold   = 1'b0;
      exp_q.delete();
      spr_bus_ack_i = 1'b0;
    end else begin
      if (spr_access_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", 32'd1, 32'd0);
          spr_bus_ack_i = 1'b0;
        end else begin
          chk("spr_we", {31'd0, spr_we_o}, {31'd0, exp_q[0].we});
          chk("spr_addr", {16'd0, spr_addr_o}, {16'd0, exp_q[0].addr});
          chk("spr_dat", spr_dat_o, exp_q[0].dat);
          spr_bus_ack_i = (acc_cycles == exp_q[0].delay);
          spr_dat_i     = spr_bus_ack_i ? exp_q[0].rdata : $urandom;
        end
        acc_cycles++;
      end else begin
        chk("spr_we_idle", {31'd0, spr_we_o}, 32'd0);
        // Random noise on ack outside ACCESS must be ignored.
        spr_bus_ack_i = $urandom_range(0, 1) == 1;
        spr_dat_i     = $urandom;
      end
      if (rsp_valid_o) begin
        chk("resp_req_ready", {31'd0, req_ready_o}, 32'd0);
        if (prev_hold) begin
          chk("rsp_dat_stable", rsp_dat_o, prev_dat);
          chk("rsp_err_stable", {31'd0, rsp_err_o}, {31'd0, prev_err});
        end else begin
          chk("rsp_latency", {31'd0, prev_access}, 32'd1);
        end
        if (rsp_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            txn_t t;
            t = exp_q.pop_front();
            chk("rsp_dat", rsp_dat_o, t.exp_dat);
            chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, t.exp_err});
            chk("access_cycles", acc_cycles, t.exp_acc);
          end
          acc_cycles = 0;
        end
      end
      prev_access = spr_access_o;
      prev_hold   = rsp_valid_o && !rsp_ready_i;
      prev_dat    = rsp_dat_o;
      prev_err    = rsp_err_o;
    end
  end

  // Waits for IDLE while throwing junk requests at the busy DUT, then issues one request.
  task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d,
                       input int dly, input logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 200) begin
      req_valid_i = $urandom_range(0, 1) == 1;
      req_we_i    = $urandom_range(0, 1) == 1;
      req_addr_i  = 16'($urandom);
      req_dat_i   = $urandom;
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("req_ready_timeout", 32'd0, 32'd1);
    exp_q.push_back(model(we, a, d, dly, rd));
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_dat_i   = d;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = 16'($urandom);
    req_dat_i   = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    chk("reset_rsp_dat", rsp_dat_o, 32'd0);
    chk("reset_access", {31'd0, spr_access_o}, 32'd0);
    chk("reset_spr_addr", {16'd0, spr_addr_o}, 32'd0);
    chk("reset_spr_dat", spr_dat_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases: zero-wait write, 3-wait read, timeout, ack on the last cycle.
    issue(1'b1, 16'h5000, 32'h6000_0010, 0, 32'hdead_beef);
    issue(1'b0, 16'h5001, 32'h0, 3, 32'h0000_0123);
    issue(1'b0, 16'h5002, 32'h0, TIMEOUT + 4, 32'h1111_2222);
    issue(1'b0, 16'h5003, 32'h0, TIMEOUT - 1, 32'h3333_4444);
    issue(1'b1, 16'h5004, 32'h5555_6666, TIMEOUT, 32'h7777_8888);
    drain();

    // Random traffic, biased toward the timeout boundary.
    for (int i = 0; i < 40; i++) begin
      int dly;
      dly = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                        : $urandom_range(0, TIMEOUT + 4);
      issue($urandom_range(0, 1) == 1, 16'($urandom), $urandom, dly, $urandom);
    end
    drain();

    // Backpressure: response held for 5 cycles while requests knock on the door.
    hold_low = 1'b1;
    issue(1'b0, 16'h2a00, 32'h0, 2, 32'hcafe_f00d);
    begin
      int n;
      n = 0;
      while (!rsp_valid_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("rsp_valid_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      req_valid_i = ~req_valid_i;
      req_addr_i  = 16'($urandom);
      @(negedge clk);
      chk("hold_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
    end
    req_valid_i = 1'b0;
    hold_low = 1'b0;
    drain();

    // Reset in the second ACCESS cycle aborts with no response.
    issue(1'b1, 16'h7777, 32'h1234_5678, 10, 32'h0);
    @(posedge clk);
    #1;
    chk("abort_in_access", {31'd0, spr_access_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_access", {31'd0, spr_access_o}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("abort_spr_addr", {16'd0, spr_addr_o}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    end

    // Traffic still works after the abort.
    issue(1'b0, 16'h0011, 32'h0, 1, 32'h0bad_cafe);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
